// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP TX scheduler: FSM encoding and MAC beat field widths.
package udp_tx_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int DATA_W = 32;
  localparam int MOD_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    GRANT = S_GRANT,
    XFER  = S_XFER,
    GAP   = S_GAP
  } state_t;

endpackage

// File: rtl/udp_tx_scheduler_rr_pick.sv
// Combinational round-robin selector: first eligible source above last_grant, wrapping.
module rr_pick
  import udp_tx_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  always_comb begin
    int cand;
    cand   = 0;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N) cand = cand - N;
      if (!any && eligible[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        index        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one MAC TX stream between packet sources,
// with packet-boundary grants, inter-packet gap and a stall watchdog.
//
// state | meaning
// IDLE  | arbitrate among src_req & src_en
// GRANT | granted, waiting for the sop beat (watchdog drops the grant)
// XFER  | forwarding beats until eop (watchdog emits an error eop)
// GAP   | GAP_CYC idle cycles before the next arbitration
module udp_tx_scheduler
  import udp_tx_pkg::*;
#(
  parameter int N_SRC   = 3,
  parameter int TIMEOUT = 1024,
  parameter int GAP_CYC = 4,
  parameter int TO_W    = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_req,
  input  logic [N_SRC-1:0]        src_en,
  input  logic [N_SRC-1:0]        src_wren,
  input  logic [N_SRC-1:0]        src_sop,
  input  logic [N_SRC-1:0]        src_eop,
  input  logic [MOD_W*N_SRC-1:0]  src_mod,
  input  logic [DATA_W*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]        src_rdy,
  output logic [N_SRC-1:0]        gnt,
  input  logic                    tx_rdy,
  output logic                    tx_wren,
  output logic                    tx_sop,
  output logic                    tx_eop,
  output logic [MOD_W-1:0]        tx_mod,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_err,
  output logic                    drop_pulse
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  // With no gap configured, a finished packet returns straight to arbitration.
  localparam state_t AFTER_PKT = (GAP_CYC == 0) ? IDLE : GAP;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [TO_W-1:0]    wd_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               sel_wren, sel_sop, sel_eop;
  logic [MOD_W-1:0]   sel_mod;
  logic [DATA_W-1:0]  sel_data;

  assign eligible = src_req & src_en;
  assign src_rdy  = ((state == GRANT) || (state == XFER)) ? (gnt & {N_SRC{tx_rdy}}) : '0;

  rr_pick #(.N(N_SRC), .IDX_W(IDX_W)) u_rr_pick (
    .eligible  (eligible),
    .last_grant(last_grant),
    .onehot    (pick_oh),
    .index     (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    sel_wren = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_mod  = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        sel_wren = src_wren[i];
        sel_sop  = src_sop[i];
        sel_eop  = src_eop[i];
        sel_mod  = src_mod[MOD_W*i +: MOD_W];
        sel_data = src_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      last_grant <= IDX_W'(N_SRC - 1);
      wd_cnt     <= '0;
      gap_cnt    <= '0;
      tx_wren    <= 1'b0;
      tx_sop     <= 1'b0;
      tx_eop     <= 1'b0;
      tx_mod     <= '0;
      tx_data    <= '0;
      tx_err     <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      tx_wren    <= 1'b0;
      tx_sop     <= 1'b0;
      tx_eop     <= 1'b0;
      tx_mod     <= '0;
      tx_data    <= '0;
      tx_err     <= 1'b0;
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt  <= '0;
          gap_cnt <= '0;
          if (pick_any) begin
            gnt        <= pick_oh;
            last_grant <= pick_idx;
            state      <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          if (sel_wren && sel_sop) begin
            tx_wren <= 1'b1;
            tx_sop  <= 1'b1;
            tx_eop  <= sel_eop;
            tx_mod  <= sel_eop ? sel_mod : '0;
            tx_data <= sel_data;
            wd_cnt  <= '0;
            // A single-beat packet closes the grant immediately.
            if (sel_eop) begin
              gnt   <= '0;
              state <= AFTER_PKT;
            end else begin
              state <= XFER;
            end
          end else if (wd_cnt == TO_LAST) begin
            gnt        <= '0;
            drop_pulse <= 1'b1;
            state      <= AFTER_PKT;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        XFER: begin
          if (sel_wren) begin
            tx_wren <= 1'b1;
            tx_sop  <= sel_sop;
            tx_eop  <= sel_eop;
            tx_mod  <= sel_eop ? sel_mod : '0;
            tx_data <= sel_data;
            wd_cnt  <= '0;
            if (sel_eop) begin
              gnt   <= '0;
              state <= AFTER_PKT;
            end
          end else if (wd_cnt == TO_LAST) begin
            tx_wren    <= 1'b1;
            tx_eop     <= 1'b1;
            tx_err     <= 1'b1;
            drop_pulse <= 1'b1;
            gnt        <= '0;
            state      <= AFTER_PKT;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed self-checking bench for udp_tx_scheduler (3 sources, short watchdog).
module tb_udp_tx_scheduler;

  localparam int N       = 3;
  localparam int TIMEOUT = 20;
  localparam int GAP_CYC = 4;
  localparam int TO_W    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_req, src_en, src_wren, src_sop, src_eop, src_rdy, gnt;
  logic [2*N-1:0]  src_mod;
  logic [32*N-1:0] src_data;
  logic            tx_rdy, tx_wren, tx_sop, tx_eop, tx_err, drop_pulse;
  logic [1:0]      tx_mod;
  logic [31:0]     tx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sop_cyc = 0;
  int eop_cyc = 0;

  udp_tx_scheduler #(.N_SRC(N), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_en(src_en), .src_wren(src_wren), .src_sop(src_sop),
    .src_eop(src_eop), .src_mod(src_mod), .src_data(src_data), .src_rdy(src_rdy),
    .gnt(gnt), .tx_rdy(tx_rdy), .tx_wren(tx_wren), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_mod(tx_mod), .tx_data(tx_data), .tx_err(tx_err), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    src_wren = '0; src_sop = '0; src_eop = '0; src_mod = '0; src_data = '0;
  endtask

  // Drives one beat on source s plus an unrelated noise beat on the next source.
  task automatic drive_beat(input int s, input logic sop, input logic eop,
                            input logic [1:0] m, input logic [31:0] d);
    int o;
    clear_beats();
    o = (s + 1) % N;
    src_wren[s] = 1'b1; src_sop[s] = sop; src_eop[s] = eop;
    src_mod[2*s +: 2] = m; src_data[32*s +: 32] = d;
    src_wren[o] = 1'b1; src_sop[o] = 1'b1; src_eop[o] = 1'b1;
    src_mod[2*o +: 2] = 2'd1; src_data[32*o +: 32] = 32'hDEAD_0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_req = '0; src_en = '1; tx_rdy = 1'b1;
    clear_beats();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt();
    int w;
    w = 0;
    while (gnt == '0 && w < 60) begin tick(); w++; end
  endtask

  // Waits for src_rdy, honours ready latency 1, then sends nb beats and checks each tx beat.
  task automatic send_pkt(input int s, input int nb, input logic [31:0] base, input logic [1:0] m);
    int w;
    logic [37:0] got, exp;
    w = 0;
    while (!src_rdy[s] && w < 60) begin tick(); w++; end
    checks++;
    if (src_rdy[s] !== 1'b1) begin
      errors++; $display("FAIL pkt_rdy src %0d: got %b want 1", s, src_rdy[s]);
    end
    tick();
    for (int b = 0; b < nb; b++) begin
      drive_beat(s, b == 0, b == nb - 1, (b == nb - 1) ? m : 2'd3, base + 32'(b));
      tick();
      exp = {1'b1, b == 0, b == nb - 1, (b == nb - 1) ? m : 2'd0, base + 32'(b), 1'b0};
      got = {tx_wren, tx_sop, tx_eop, tx_mod, tx_data, tx_err};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pkt_beat src %0d beat %0d: got %h want %h", s, b, got, exp);
      end
      if (b == 0) sop_cyc = cyc;
      if (b == nb - 1) eop_cyc = cyc;
    end
    clear_beats();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_req = '0; src_en = '1; tx_rdy = 1'b1;
    clear_beats();
    tick(); tick();
    checks++; if (tx_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", tx_wren); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop_pulse); end
    checks++; if ({tx_sop, tx_eop, tx_err, tx_mod, tx_data} !== 37'd0) begin
      errors++; $display("FAIL reset_tx: got %h want 0", {tx_sop, tx_eop, tx_err, tx_mod, tx_data});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_packet();
    src_req = 3'b001;
    wait_gnt();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b want 001", gnt); end
    src_req = 3'b000;
    tx_rdy = 1'b0; #1;
    checks++; if (src_rdy !== 3'b000) begin errors++; $display("FAIL rdy_low: got %b want 000", src_rdy); end
    tx_rdy = 1'b1; #1;
    checks++; if (src_rdy !== 3'b001) begin errors++; $display("FAIL rdy_high: got %b want 001", src_rdy); end
    send_pkt(0, 4, 32'hA000_0000, 2'd2);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL single_gnt_clr: got %b want 000", gnt); end
    tick();
    checks++; if (tx_wren !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", tx_wren); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [4];
    int prev_eop, idle;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    do_reset();
    prev_eop = 0;
    src_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt();
      checks++;
      if (gnt !== order[k]) begin errors++; $display("FAIL rr_order %0d: got %b want %b", k, gnt, order[k]); end
      send_pkt(k % 3, 2, 32'hB000_0000 + 32'(k << 8), 2'd1);
      if (k > 0) begin
        idle = sop_cyc - prev_eop - 1;
        checks++;
        if (idle < GAP_CYC + 2) begin errors++; $display("FAIL rr_gap %0d: got %0d want >= %0d", k, idle, GAP_CYC + 2); end
      end
      prev_eop = eop_cyc;
    end
    src_req = '0;
    repeat (10) tick();
  endtask

  task automatic test_enable_mask();
    logic seen;
    seen = 1'b0;
    src_req = 3'b010; src_en = 3'b101;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_wren || gnt != '0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL en_masked: got activity %b want 0", seen); end
    src_en = 3'b111;
    wait_gnt();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL en_gnt: got %b want 010", gnt); end
    src_req = '0;
    send_pkt(1, 2, 32'hC000_0000, 2'd3);
    repeat (10) tick();
  endtask

  task automatic test_no_sop_timeout();
    int n;
    logic seen;
    src_req = 3'b100;
    wait_gnt();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL nosop_gnt: got %b want 100", gnt); end
    src_req = 3'b101;
    src_wren[2] = 1'b1; src_sop[2] = 1'b0; src_data[95:64] = 32'h1234_5678;
    n = 0; seen = 1'b0;
    while (!drop_pulse && n < TIMEOUT + 10) begin
      tick(); n++;
      if (tx_wren) seen = 1'b1;
    end
    clear_beats();
    checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL nosop_cycles: got %0d want %0d", n, TIMEOUT); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL nosop_no_beat: got %b want 0", seen); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL nosop_gnt_clr: got %b want 000", gnt); end
    tick();
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL nosop_pulse_len: got %b want 0", drop_pulse); end
    n = 1;
    while (gnt == '0 && n < 40) begin tick(); n++; end
    checks++; if (n !== GAP_CYC + 1) begin errors++; $display("FAIL nosop_regrant_delay: got %0d want %0d", n, GAP_CYC + 1); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL nosop_next: got %b want 001", gnt); end
    src_req = '0;
    send_pkt(0, 3, 32'hD000_0000, 2'd0);
    repeat (10) tick();
  endtask

  task automatic test_stall_abort();
    int n, w;
    logic [37:0] got;
    src_req = 3'b010;
    wait_gnt();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL stall_gnt: got %b want 010", gnt); end
    src_req = '0;
    w = 0;
    while (!src_rdy[1] && w < 20) begin tick(); w++; end
    tick();
    drive_beat(1, 1'b1, 1'b0, 2'd0, 32'hE000_0001);
    tick();
    checks++; if ({tx_wren, tx_sop, tx_data} !== {2'b11, 32'hE000_0001}) begin
      errors++; $display("FAIL stall_beat1: got %h want %h", {tx_wren, tx_sop, tx_data}, {2'b11, 32'hE000_0001});
    end
    drive_beat(1, 1'b0, 1'b0, 2'd0, 32'hE000_0002);
    tick();
    checks++; if ({tx_wren, tx_sop, tx_data} !== {2'b10, 32'hE000_0002}) begin
      errors++; $display("FAIL stall_beat2: got %h want %h", {tx_wren, tx_sop, tx_data}, {2'b10, 32'hE000_0002});
    end
    clear_beats();
    n = 0;
    tick(); n++;
    while (!tx_wren && n < TIMEOUT + 10) begin tick(); n++; end
    checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", n, TIMEOUT); end
    got = {tx_wren, tx_sop, tx_eop, tx_mod, tx_data, tx_err};
    checks++; if (got !== {3'b101, 2'd0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL stall_abort_beat: got %h want %h", got, {3'b101, 2'd0, 32'd0, 1'b1});
    end
    checks++; if ({drop_pulse, gnt} !== 4'b1000) begin
      errors++; $display("FAIL stall_drop: got %b want 1000", {drop_pulse, gnt});
    end
    tick();
    checks++; if ({tx_wren, tx_err, drop_pulse} !== 3'b000) begin
      errors++; $display("FAIL stall_after: got %b want 000", {tx_wren, tx_err, drop_pulse});
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_xfer();
    int w;
    src_req = 3'b100;
    wait_gnt();
    src_req = '0;
    w = 0;
    while (!src_rdy[2] && w < 20) begin tick(); w++; end
    tick();
    drive_beat(2, 1'b1, 1'b0, 2'd0, 32'hF000_0001);
    tick();
    checks++; if (tx_wren !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", tx_wren); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({tx_wren, tx_sop, tx_data, gnt, src_rdy} !== 40'd0) begin
      errors++; $display("FAIL rstmid_async: got %h want 0", {tx_wren, tx_sop, tx_data, gnt, src_rdy});
    end
    clear_beats();
    tick();
    rst = 1'b0;
    src_req = 3'b111;
    wait_gnt();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rstmid_first: got %b want 001", gnt); end
    src_req = '0;
    send_pkt(0, 2, 32'h5500_0000, 2'd2);
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_enable_mask();
    test_no_sop_timeout();
    test_stall_abort();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
